// File: rtl/seq_serializer_if.sv
// Parallel-word handshake plus serial-stream outputs of the serializer.
// The producer/observer uses master; the serializer uses slave.
interface seq_serializer_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             word_done;
   logic             busy;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready,
      input  ser_out,
      input  ser_valid,
      input  word_done,
      input  busy
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready,
      output ser_out,
      output ser_valid,
      output word_done,
      output busy
   );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-in, serial-out front end: one holding register feeding a shift register,
// with optional idle gap between words and a fixed idle level on ser_out.
module seq_serializer #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned GAP_CYCLES = 0,
   parameter bit          IDLE_BIT   = 1'b0
) (
   input logic             clk,
   input logic             reset,
   seq_serializer_if.slave sif
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam bit          HasGap = (GAP_CYCLES > 0);
   localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
   localparam logic [GapW-1:0] GapLast = HasGap ? GapW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] hold_q;
   logic             hold_full_q, hold_full_d;
   logic             accept;
   logic             load;
   logic             head;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      load      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hold_full_q) begin
               load    = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            if (bit_cnt_q == BitLast) begin
               if (HasGap) begin
                  state_d   = StGap;
                  gap_cnt_d = '0;
               end else if (hold_full_q) begin
                  // Reload straight from hold so consecutive words have no bubble.
                  load = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CntW'(1);
               shift_d   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
            end
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               if (hold_full_q) begin
                  load    = 1'b1;
                  state_d = StShift;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GapW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         shift_d   = hold_q;
         bit_cnt_d = '0;
      end
   end

   always_comb begin
      head           = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
      sif.data_ready = ~hold_full_q & ~reset;
      sif.ser_valid  = (state_q == StShift);
      sif.ser_out    = (state_q == StShift) ? head : IDLE_BIT;
      sif.word_done  = (state_q == StShift) && (bit_cnt_q == BitLast);
      sif.busy       = (state_q != StIdle) || hold_full_q;
      accept         = sif.data_valid & ~hold_full_q & ~reset;
      // Accept and load are exclusive: accept needs hold empty, load needs it full.
      hold_full_d    = accept | (hold_full_q & ~load);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         hold_full_q <= hold_full_d;
         if (accept) begin
            hold_q <= sif.data_in;
         end
      end
   end

endmodule
